// File: rtl/clarvi_load_assembler_pkg.sv
// Shared load-path types for the clarvi byte-serial load assembler.
package clarvi_load_assembler_pkg;

    typedef enum logic [1:0] {
        B = 2'd0,
        H = 2'd1,
        W = 2'd2,
        D = 2'd3
    } mem_width_t;

    localparam int NUM_LOAD_PARTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } load_asm_state_t;

    function automatic logic [3:0] load_bytes(input mem_width_t width);
        case (width)
            B:       return 4'd1;
            H:       return 4'd2;
            W:       return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/clarvi_load_extend.sv
// Combinational sign/zero extension of an assembled 8-byte load value.
module clarvi_load_extend
    import clarvi_load_assembler_pkg::*;
(
    input  logic [NUM_LOAD_PARTS-1:0][7:0] raw_bytes,
    input  mem_width_t                     width,
    input  logic                           is_unsigned,
    output logic [NUM_LOAD_PARTS-1:0][7:0] ext_bytes
);
    logic [3:0] num_bytes;
    logic [2:0] sign_idx;
    logic [7:0] fill;

    // Bytes beyond the load width take the fill byte; a D load keeps everything.
    always_comb begin
        num_bytes = load_bytes(width);
        sign_idx  = 3'(num_bytes - 4'd1);
        fill      = is_unsigned ? 8'h00 : {8{raw_bytes[sign_idx][7]}};
        for (int i = 0; i < NUM_LOAD_PARTS; i++) begin
            ext_bytes[i] = (4'(i) < num_bytes) ? raw_bytes[i] : fill;
        end
    end

endmodule

// File: rtl/clarvi_load_assembler.sv
// Byte-serial load assembler: collects eight returned bytes, extends, drains to writeback.
// Optional macro CLARVI_LOAD_CHECK_EN adds a sticky part-order protocol checker on load_error.
module clarvi_load_assembler
    import clarvi_load_assembler_pkg::*;
#(
    parameter int NUM_PARTS = NUM_LOAD_PARTS,
    parameter int RD_WIDTH  = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         read_issue,
    input  logic [$clog2(NUM_PARTS)-1:0] issue_part,
    input  mem_width_t                   issue_width,
    input  logic                         issue_unsigned,
    input  logic [RD_WIDTH-1:0]          issue_rd,
    input  logic                         main_read_pending,
    input  logic [7:0]                   main_read_data,
    output logic                         load_busy,
    output logic                         wb_valid,
    output logic [$clog2(NUM_PARTS)-1:0] wb_part,
    output logic [7:0]                   wb_byte,
    output logic [RD_WIDTH-1:0]          wb_rd,
    output logic                         load_error
);
    localparam int                PART_W    = $clog2(NUM_PARTS);
    localparam logic [PART_W-1:0] LAST_PART = PART_W'(NUM_PARTS - 1);

    load_asm_state_t           state;
    logic [PART_W-1:0]         ret_part;
    logic [PART_W-1:0]         drain_cnt;
    logic [NUM_PARTS-1:0][7:0] data_buf;
    logic [NUM_PARTS-1:0][7:0] capture_buf;
    logic [NUM_PARTS-1:0][7:0] ext_buf;
    mem_width_t                ctx_width;
    logic                      ctx_unsigned;
    logic [RD_WIDTH-1:0]       ctx_rd;
    logic                      in_drain;

    // Extension must see the final byte arriving this cycle, not the stale slot.
    always_comb begin
        capture_buf           = data_buf;
        capture_buf[ret_part] = main_read_data;
    end

    clarvi_load_extend u_extend (
        .raw_bytes   (capture_buf),
        .width       (ctx_width),
        .is_unsigned (ctx_unsigned),
        .ext_bytes   (ext_buf)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            ret_part     <= '0;
            drain_cnt    <= '0;
            data_buf     <= '0;
            ctx_width    <= B;
            ctx_unsigned <= 1'b0;
            ctx_rd       <= '0;
        end else begin
            if (read_issue && !stall) begin
                ret_part <= issue_part;
                if (issue_part == '0) begin
                    ctx_width    <= issue_width;
                    ctx_unsigned <= issue_unsigned;
                    ctx_rd       <= issue_rd;
                end
            end

            // Returns are captured regardless of stall; a return during DRAIN is dropped.
            case (state)
                IDLE: begin
                    if (main_read_pending) begin
                        data_buf[ret_part] <= main_read_data;
                        if (ret_part == '0) begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (main_read_pending) begin
                        if (ret_part == LAST_PART) begin
                            data_buf  <= ext_buf;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            data_buf[ret_part] <= main_read_data;
                        end
                    end
                end
                DRAIN: begin
                    if (!stall) begin
                        if (drain_cnt == LAST_PART) begin
                            drain_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_drain  = (state == DRAIN);
    assign load_busy = in_drain && !((drain_cnt == LAST_PART) && !stall);
    assign wb_valid  = in_drain;
    assign wb_part   = in_drain ? drain_cnt : '0;
    assign wb_byte   = in_drain ? data_buf[drain_cnt] : 8'h00;
    assign wb_rd     = in_drain ? ctx_rd : '0;

`ifdef CLARVI_LOAD_CHECK_EN
    logic [PART_W-1:0] expected_part;

    // Expected part follows the observed one so a single gap raises one sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            expected_part <= '0;
            load_error    <= 1'b0;
        end else if (main_read_pending) begin
            if (state == DRAIN) begin
                load_error <= 1'b1;
            end else begin
                expected_part <= ret_part + 1'b1;
                if ((ret_part != expected_part) || ((state == COLLECT) && (ret_part == '0))) begin
                    load_error <= 1'b1;
                end
            end
        end
    end
`else
    assign load_error = 1'b0;
`endif

endmodule

// File: doc/clarvi_load_assembler.md
Name: clarvi_load_assembler

Overview:
- Sits directly downstream of the byte-serial memory access stage: consumes the eight byte-wide read returns of one load, which always arrive as parts 0..7 in order.
- Assembles the bytes into a 64-bit buffer, applies sign- or zero-extension according to the load width, then drains the result byte-serially to the register-writeback path, parts 0..7.
- Asserts a busy stall while draining so no new load is issued until the buffer is free.

Parameters:
- NUM_PARTS, 8, bytes per 64-bit value; part index width is clog2(NUM_PARTS) = 3.
- RD_WIDTH, 5, destination register index width.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  global pipeline stall; freezes issue capture and drain
- read_issue  input  1  a byte read is issued to memory this cycle (the access stage's main_read_enable)
- issue_part  input  3  part index of the issued read (the access stage's access_part)
- issue_width  input  mem_width_t  load width B/H/W/D; sampled on the part-0 issue
- issue_unsigned  input  1  zero-extend when 1; sampled on the part-0 issue
- issue_rd  input  RD_WIDTH  destination register; sampled on the part-0 issue
- main_read_pending  input  1  registered issue flag; read data is valid this cycle
- main_read_data  input  8  returned memory byte
- load_busy  output  1  stall request to upstream stages
- wb_valid  output  1  writeback byte valid
- wb_part  output  3  byte index of wb_byte
- wb_byte  output  8  extended result byte
- wb_rd  output  RD_WIDTH  destination register
- load_error  output  1  sticky protocol error (optional feature only)

Behaviour:
- Fixed memory latency of 1: data for an issue in cycle t arrives in t+1 with main_read_pending=1.
- ret_part register: loaded with issue_part when read_issue && !stall.
- Data capture ignores stall. Returned data is always written: buf[ret_part] <= main_read_data.
- Part-0 issue with !stall latches issue_width, issue_unsigned and issue_rd into ctx registers.
- States: IDLE, COLLECT, DRAIN.
  - IDLE -> COLLECT on a return with ret_part==0.
  - COLLECT -> DRAIN on a return with ret_part==7.
  - DRAIN -> IDLE after the part-7 byte is emitted.
- Extension is applied on the COLLECT->DRAIN transition into the buffer:
  - n = 1, 2, 4 or 8 bytes for B, H, W, D.
  - Bytes n..7 are replaced by 8'h00 if unsigned, otherwise by {8{buf[n-1][7]}}.
  - D is unchanged.
- DRAIN:
  - wb_valid=1, wb_part=drain_cnt, wb_byte=buf[drain_cnt], wb_rd=ctx_rd.
  - drain_cnt advances only when !stall.
  - While stalled, all wb outputs hold their values.
- load_busy is combinational: (state==DRAIN) && !(drain_cnt==7 && !stall).
  - This allows a new issue in the final drain cycle. Its data returns once the state is IDLE, so a return never coincides with DRAIN.
- Outputs outside DRAIN: wb_valid=0, wb_part=0, wb_byte=0, wb_rd=0.
- Reset (including mid-load):
  - State IDLE, drain_cnt=0, ret_part=0, buffer and ctx cleared.
  - All outputs 0, load_error=0.
  - Partial loads are discarded.
- A return while in DRAIN is a protocol violation: the byte is dropped and the buffer is untouched.

Optional Feature:
- Macro: CLARVI_LOAD_CHECK_EN.
- Defined: a checker tracks expected_part.
  - load_error is set and held until reset on any of:
    - a return whose ret_part differs from the expected part;
    - a return during DRAIN;
    - a part-0 return while in COLLECT.
  - The FSM still follows ret_part.
- Undefined: no checker logic; load_error is tied to 0.

Decomposition:
- Shared riscv package (existing): mem_width_t, plus new constants.
  - NUM_LOAD_PARTS=8.
  - Width-to-byte-count function load_bytes(mem_width_t).
  - Enum load_asm_state_t {IDLE, COLLECT, DRAIN}.
- One sub-module: clarvi_load_extend, purely combinational, taking the 8-byte buffer, width and unsigned, and returning the extended 8 bytes.
- The checker stays inline under the macro.

Test Plan:
- LB signed, bytes 0x80,0x11..0x77, rd=5 -> DRAIN emits 0x80 then seven 0xFF, parts 0..7, wb_rd=5, load_busy high for 7 cycles.
- LHU, bytes 0x34,0x12,0xAA.. -> wb bytes 0x34,0x12, then six 0x00.
- LD, bytes 0x01..0x08, stall asserted for 3 cycles at drain_cnt=2 -> wb holds part 2 / 0x03 for 4 cycles total, then resumes; still 8 distinct beats.
- Back-to-back LW: new part-0 issue in the final drain cycle -> no data loss; second result emitted; load_busy low in that cycle.
- Reset asserted after part 3 returns, then a full LB load -> first wb_valid belongs to the new load; no stale bytes.
- CLARVI_LOAD_CHECK_EN: returns with parts 0,1,3 -> load_error=1 after the part-3 return and held until reset; without the macro load_error stays 0.
